// File: rtl/johnson_counter_pkg.sv
// Shared constants for the Johnson counter slice.
package johnson_counter_pkg;

  localparam int unsigned MinWidth = 2;

endpackage

// File: rtl/johnson_legal_chk.sv
// Flags a Johnson-counter state as legal when it has at most one adjacent-bit transition,
// i.e. it is one of the 2*WIDTH thermometer patterns.
module johnson_legal_chk #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] q_i,
  output logic             legal_o
);

  logic [WIDTH-2:0] diff;

  assign diff    = q_i[WIDTH-1:1] ^ q_i[WIDTH-2:0];
  assign legal_o = $onehot0(diff);

endmodule

// File: rtl/johnson_counter.sv
// Self-correcting Johnson (twisted-ring) counter with count enable; 2*WIDTH-state cycle,
// one bit changes per step, any illegal state returns to zero on the next edge.
module johnson_counter
  import johnson_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  localparam int unsigned PERIOD = 2 * WIDTH;

  if (PERIOD < 2 * MinWidth) begin : g_width_chk
    $error("johnson_counter: WIDTH must be >= %0d", MinWidth);
  end

  logic [WIDTH-1:0] q_q, q_d;
  logic             legal;

  johnson_legal_chk #(
    .WIDTH(WIDTH)
  ) u_legal_chk (
    .q_i    (q_q),
    .legal_o(legal)
  );

  // Correction wins over enable; an unknown enable falls through to hold.
  always_comb begin
    q_d = q_q;
    if (!legal) begin
      q_d = '0;
    end else if (en) begin
      q_d = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_johnson_counter.sv
// Directed self-checking bench for johnson_counter at WIDTH = 4, 2 and 8.
module tb_johnson_counter;

  logic       clk;
  logic       rst;
  logic       en4, en2, en8;
  logic [3:0] q4;
  logic [1:0] q2;
  logic [7:0] q8;

  int unsigned checks = 0;
  int unsigned errors = 0;

  johnson_counter #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .en(en4), .q(q4));
  johnson_counter #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .en(en2), .q(q2));
  johnson_counter #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .en(en8), .q(q8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Thermometer state k of a w-bit Johnson cycle, counted from all-zero.
  function automatic logic [31:0] thermo(input int k, input int w);
    logic [31:0] ones;
    ones = (32'd1 << w) - 32'd1;
    if (k <= w) return (32'd1 << k) - 32'd1;
    return (ones << (k - w)) & ones;
  endfunction

  function automatic int adj_edges(input logic [3:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 3; i++) if (v[i] != v[i+1]) n++;
    return n;
  endfunction

  logic [3:0] seq4 [8];
  logic [1:0] seq2 [4];
  logic [7:0] prev8;
  logic [1:0] prev2;
  int         idx4;
  logic       en_r;

  initial begin
    seq4 = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    seq2 = '{2'b01, 2'b11, 2'b10, 2'b00};
    rst = 1'b1;
    en4 = 1'b0;
    en2 = 1'b0;
    en8 = 1'b0;

    // Reset is asynchronous and holds across a clock edge.
    #1 rst = 1'b0;
    #1 chk("reset_async", q4, 4'b0000);
    tick();
    chk("reset_hold_clk", q4, 4'b0000);
    chk("reset_w8", q8, 8'h00);
    #4;
    rst = 1'b1;
    en4 = 1'b1;

    // Full sequence twice, checking the wrap and repeat.
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("seq4", q4, seq4[k % 8]);
    end

    // Hold at 0111 for three clocks, then resume.
    for (int k = 0; k < 3; k++) tick();
    chk("reach_0111", q4, 4'b0111);
    en4 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hold_0111", q4, 4'b0111);
    end
    en4 = 1'b1;
    tick();
    chk("resume_1111", q4, 4'b1111);
    tick();
    chk("reach_1110", q4, 4'b1110);

    // Mid-operation async reset between edges.
    #3 rst = 1'b0;
    #1 chk("midreset_async", q4, 4'b0000);
    rst = 1'b1;
    tick();
    chk("after_release", q4, 4'b0001);

    // Illegal state with en low: recovers to zero, then steps.
    en4 = 1'b0;
    force dut4.q_q = 4'b0101;
    #1 release dut4.q_q;
    #1 chk("deposit_0101", q4, 4'b0101);
    tick();
    chk("correct_0101", q4, 4'b0000);
    en4 = 1'b1;
    tick();
    chk("step_after_fix", q4, 4'b0001);

    // Illegal state with en high: correction overrides the step.
    force dut4.q_q = 4'b1001;
    #1 release dut4.q_q;
    tick();
    chk("correct_1001_en", q4, 4'b0000);
    en4 = 1'b0;

    // WIDTH=2 and WIDTH=8 periods, one bit flip per step.
    prev2 = q2;
    prev8 = q8;
    en2 = 1'b1;
    en8 = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk("seq2", q2, seq2[(k - 1) % 4]);
      chk("seq8", q8, thermo(k % 16, 8));
      chk("flip2", $countones(q2 ^ prev2), 1);
      chk("flip8", $countones(q8 ^ prev8), 1);
      prev2 = q2;
      prev8 = q8;
    end
    en2 = 1'b0;
    en8 = 1'b0;

    // Random enable against a step-on-enable reference model.
    chk("rand_start", q4, 4'b0000);
    idx4 = 0;
    for (int k = 0; k < 200; k++) begin
      en_r = 1'($urandom_range(0, 1));
      en4  = en_r;
      tick();
      if (en_r) idx4 = (idx4 + 1) % 8;
      chk("rand_model", q4, thermo(idx4, 4));
      chk("rand_legal", (adj_edges(q4) <= 1) ? 1 : 0, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
